// File: rtl/lut_rd_arbiter.sv
// lut_rd_arbiter
//
// Round-robin read arbiter that shares one single-port colour look-up ROM
// among NUM_REQ requesters. It accepts one lookup per cycle over a
// valid/ready handshake and registers the ROM address. A tag pipeline
// tracks which requester owns each in-flight read. The ROM byte is returned
// to that requester after a fixed latency. The block also drives the ROM's
// active-high reset, which is held for two cycles after rst_n is released.
//
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   ADDR_WIDTH ROM address width
//   DATA_WIDTH ROM data width
//   ROM_LAT    ROM read latency in clocks (1 or 2)
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester lookup request
//   req_addr   packed addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_ready  one-hot grant (combinational)
//   hold       blocks new grants; in-flight reads still complete
//   rsp_valid  one-hot, one-cycle pulse marking the owner of rsp_data
//   rsp_data   shared response bus
//   rom_addr   registered ROM address
//   rom_data   ROM read data
//   rom_rst    active-high ROM reset
//   busy       high while any read is in flight

module lut_rd_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ROM_LAT    = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          hold,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_data,
    output logic                          rom_rst,
    output logic                          busy
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One stage for the address register, ROM_LAT stages for the ROM itself.
    localparam int unsigned DEPTH = ROM_LAT + 1;

    logic [PTR_W-1:0]      last_q;
    logic [NUM_REQ-1:0]    gnt;
    logic [PTR_W-1:0]      gnt_idx;
    logic                  gnt_found;
    logic                  gnt_en;
    logic                  xfer;

    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [DEPTH-1:0]      tag_vld_q;
    logic [NUM_REQ-1:0]    tag_own_q [DEPTH];
    logic [NUM_REQ-1:0]    rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [1:0]            rst_cnt_q;
    logic                  rom_rst_q;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        logic [PTR_W-1:0] idx;
        gnt       = '0;
        gnt_idx   = last_q;
        gnt_found = 1'b0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((32'(last_q) + k) % NUM_REQ);
            if (!gnt_found && req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx;
            end
        end
        if (gnt_found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign gnt_en    = ~hold & ~rom_rst_q;
    assign req_ready = gnt_en ? gnt : '0;
    assign xfer      = gnt_en & gnt_found;

    // Grant pointer and ROM address register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= PTR_W'(NUM_REQ - 1);
            rom_addr_q <= '0;
        end else if (xfer) begin
            last_q     <= gnt_idx;
            rom_addr_q <= req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

    // Tag pipeline: {valid, one-hot owner} follows each read through the ROM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_own_q[i] <= '0;
            end
        end else begin
            tag_vld_q    <= {tag_vld_q[DEPTH-2:0], xfer};
            tag_own_q[0] <= xfer ? gnt : '0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                tag_own_q[i] <= tag_own_q[i-1];
            end
        end
    end

    // Return stage: capture ROM data for the owner of the oldest tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else if (tag_vld_q[DEPTH-1]) begin
            rsp_valid_q <= tag_own_q[DEPTH-1];
            rsp_data_q  <= rom_data;
        end else begin
            rsp_valid_q <= '0;
        end
    end

    // ROM reset: set asynchronously, released on the second edge after rst_n rises.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_q <= 2'd0;
            rom_rst_q <= 1'b1;
        end else if (rst_cnt_q != 2'd2) begin
            rst_cnt_q <= rst_cnt_q + 2'd1;
            rom_rst_q <= (rst_cnt_q + 2'd1) != 2'd2;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rom_addr  = rom_addr_q;
    assign rom_rst   = rom_rst_q;
    assign busy      = |tag_vld_q;

endmodule
